datapath: RTL and testbench

Single-cycle register-file/ALU datapath: two combinational read ports of a 4×32-bit register file feed a 32-bit ALU, and the ALU result is written back to a third addressed register on the clock edge when enabled. It is the execution core of the ALU-with-register-file lab design and has no memory or control-FSM of its own. Operation selection and register addressing come directly from ports.

---
 rtl/datapath.sv | 106 ++++++++++
 tb/tb_datapath.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// datapath: 4x32 register file with two combinational read ports feeding a
// 32-bit ALU; the ALU result is written back to register[addr3] on the rising
// clock edge when wr is high. Flags and result are combinational.

module datapath_rf (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr1,
    input  logic [1:0]  addr2,
    input  logic [1:0]  addr3,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] register [0:3];

    // Storage: reset restores the lab constants at once; writes are skipped while in reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            register[0] <= 32'h7FFF_FFFF;
            register[1] <= 32'h1234_5678;
            register[2] <= 32'h0F0F_0F0F;
            register[3] <= 32'hFFFF_0000;
        end else if (wr) begin
            register[addr3] <= wdata;
        end
    end

    // Both read ports are combinational; during a write they return the old value
    always_comb begin
        rdata1 = register[addr1];
        rdata2 = register[addr2];
    end

endmodule

module datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  alu_control,
    input  logic [1:0]  addr1,
    input  logic [1:0]  addr2,
    input  logic [1:0]  addr3,
    input  logic        wr,
    output logic [31:0] alu_result,
    output logic        overflow,
    output logic        carry
);

    logic [31:0] a_s;
    logic [31:0] b_s;
    logic [32:0] sum_s;
    logic [32:0] diff_s;
    logic        add_ov_s;
    logic        sub_ov_s;

    datapath_rf rf (
        .clk    (clk),
        .rst    (rst),
        .addr1  (addr1),
        .addr2  (addr2),
        .addr3  (addr3),
        .wr     (wr),
        .wdata  (alu_result),
        .rdata1 (a_s),
        .rdata2 (b_s)
    );

    // Shared adders: subtraction is A + ~B + 1 so bit 32 is the no-borrow carry
    always_comb begin
        sum_s    = {1'b0, a_s} + {1'b0, b_s};
        diff_s   = {1'b0, a_s} + {1'b0, ~b_s} + 33'd1;
        add_ov_s = (a_s[31] == b_s[31])  && (sum_s[31]  != a_s[31]);
        sub_ov_s = (a_s[31] == ~b_s[31]) && (diff_s[31] != a_s[31]);
    end

    // Operation decode; SLT takes N xor V of A-B and zero-extends it
    always_comb begin
        alu_result = 32'h0000_0000;
        overflow   = 1'b0;
        carry      = 1'b0;
        case (alu_control)
            3'b000: begin
                alu_result = sum_s[31:0];
                carry      = sum_s[32];
                overflow   = add_ov_s;
            end
            3'b001: begin
                alu_result = diff_s[31:0];
                carry      = diff_s[32];
                overflow   = sub_ov_s;
            end
            3'b010: alu_result = a_s & b_s;
            3'b011: alu_result = a_s ^ b_s;
            3'b100: alu_result = {31'd0, diff_s[31] ^ sub_ov_s};
            default: begin
                alu_result = 32'h0000_0000;
                overflow   = 1'b0;
                carry      = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: expected ALU outputs come from an
// arithmetic model over a shadow register file, queued when stimulus is
// applied and popped when the combinational outputs are sampled.

module tb_datapath;

    logic        clk;
    logic        rst;
    logic [2:0]  alu_control;
    logic [1:0]  addr1;
    logic [1:0]  addr2;
    logic [1:0]  addr3;
    logic        wr;
    logic [31:0] alu_result;
    logic        overflow;
    logic        carry;

    typedef struct {
        logic [31:0] res;
        logic        ov;
        logic        cy;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mreg [0:3];
    int          errors = 0;
    int          checks = 0;

    datapath dut (
        .clk         (clk),
        .rst         (rst),
        .alu_control (alu_control),
        .addr1       (addr1),
        .addr2       (addr2),
        .addr3       (addr3),
        .wr          (wr),
        .alu_result  (alu_result),
        .overflow    (overflow),
        .carry       (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: run did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint r;
        sa = $signed(a);
        sb = $signed(b);
        e.res = 32'h0;
        e.ov  = 1'b0;
        e.cy  = 1'b0;
        case (op)
            3'd0: begin
                e.res = a + b;
                e.cy  = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
                r     = sa + sb;
                e.ov  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            3'd1: begin
                e.res = a - b;
                e.cy  = (a >= b);
                r     = sa - sb;
                e.ov  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            3'd2: e.res = a & b;
            3'd3: e.res = a ^ b;
            3'd4: e.res = (sa < sb) ? 32'd1 : 32'd0;
            default: e.res = 32'h0;
        endcase
        return e;
    endfunction

    task automatic load_reset_model();
        mreg[0] = 32'h7FFF_FFFF;
        mreg[1] = 32'h1234_5678;
        mreg[2] = 32'h0F0F_0F0F;
        mreg[3] = 32'hFFFF_0000;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++)
            check_value($sformatf("%s_r%0d", tag, i), dut.rf.register[i], mreg[i]);
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic do_op(input logic [2:0] op, input logic [1:0] a1, input logic [1:0] a2,
                         input logic [1:0] a3, input logic w, input string tag);
        exp_t e;
        alu_control = op;
        addr1 = a1;
        addr2 = a2;
        addr3 = a3;
        wr    = w;
        sb_q.push_back(model(op, mreg[a1], mreg[a2]));
        #1;
        e = sb_q.pop_front();
        check_value({tag, "_res"}, alu_result, e.res);
        check_value({tag, "_ov"}, {31'd0, overflow}, {31'd0, e.ov});
        check_value({tag, "_cy"}, {31'd0, carry}, {31'd0, e.cy});
        @(posedge clk);
        if (w && rst) mreg[a3] = e.res;
        #1;
        check_regs(tag);
        @(negedge clk);
    endtask

    // Literal spot-check of outputs without a clock edge.
    task automatic check_lit(input logic [2:0] op, input logic [1:0] a1, input logic [1:0] a2,
                             input logic [31:0] res, input logic ov, input logic cy, input string tag);
        alu_control = op;
        addr1 = a1;
        addr2 = a2;
        wr    = 1'b0;
        #1;
        check_value({tag, "_res"}, alu_result, res);
        check_value({tag, "_ov"}, {31'd0, overflow}, {31'd0, ov});
        check_value({tag, "_cy"}, {31'd0, carry}, {31'd0, cy});
    endtask

    // Drop rst between edges with wr=1, confirm immediate restore and no write.
    task automatic apply_reset(input string tag);
        alu_control = 3'd0;
        addr1 = 2'd1;
        addr2 = 2'd2;
        addr3 = 2'd0;
        wr    = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        load_reset_model();
        check_regs({tag, "_imm"});
        @(posedge clk);
        #1;
        check_regs({tag, "_held"});
        @(negedge clk);
        rst = 1'b1;
        wr  = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        alu_control = 3'd0;
        addr1 = 2'd0;
        addr2 = 2'd0;
        addr3 = 2'd0;
        wr = 1'b0;
        load_reset_model();
        @(negedge clk);
        check_regs("por");
        @(negedge clk);
        rst = 1'b1;

        // Idle edges with wr=0 leave registers untouched
        for (int i = 0; i < 3; i++) do_op(3'd0, 2'd0, 2'd1, 2'(i), 1'b0, "idle");

        // Write-back sequence
        do_op(3'd0, 2'd1, 2'd2, 2'd0, 1'b1, "wb_add");
        do_op(3'd2, 2'd2, 2'd3, 2'd1, 1'b1, "wb_and");
        do_op(3'd3, 2'd2, 2'd0, 2'd3, 1'b1, "wb_xor");
        do_op(3'd1, 2'd1, 2'd3, 2'd2, 1'b1, "wb_sub");
        check_value("fin_r0", dut.rf.register[0], 32'h2143_6587);
        check_value("fin_r1", dut.rf.register[1], 32'h0F0F_0000);
        check_value("fin_r2", dut.rf.register[2], 32'hE0C2_9578);
        check_value("fin_r3", dut.rf.register[3], 32'h2E4C_6A88);

        // Mid-operation async reset with wr=1
        apply_reset("rst_mid");

        // Flags and SLT after reset
        check_lit(3'd0, 2'd0, 2'd1, 32'h9234_5677, 1'b1, 1'b0, "add_ov");
        check_lit(3'd0, 2'd3, 2'd3, 32'hFFFE_0000, 1'b0, 1'b1, "add_cy");
        check_lit(3'd1, 2'd1, 2'd1, 32'h0000_0000, 1'b0, 1'b1, "sub_zero");
        check_lit(3'd4, 2'd3, 2'd1, 32'h0000_0001, 1'b0, 1'b0, "slt_lt");
        check_lit(3'd4, 2'd1, 2'd3, 32'h0000_0000, 1'b0, 1'b0, "slt_ge");
        check_lit(3'd4, 2'd0, 2'd3, 32'h0000_0000, 1'b0, 1'b0, "slt_posneg");
        check_lit(3'd7, 2'd0, 2'd1, 32'h0000_0000, 1'b0, 1'b0, "op7");
        check_lit(3'd5, 2'd3, 2'd3, 32'h0000_0000, 1'b0, 1'b0, "op5");
        @(negedge clk);

        // Same-address read-before-write
        check_lit(3'd0, 2'd1, 2'd1, 32'h2468_ACF0, 1'b0, 1'b0, "same_pre");
        do_op(3'd0, 2'd1, 2'd1, 2'd1, 1'b1, "same");
        check_value("same_post", dut.rf.register[1], 32'h2468_ACF0);

        // Resumption after reset, then random traffic against the model
        apply_reset("rst2");
        do_op(3'd1, 2'd3, 2'd0, 2'd2, 1'b1, "resume");
        for (int i = 0; i < 40; i++)
            do_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rnd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
